// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, MIPS opcode/funct
// fields, datapath select codes and the one-hot instruction-class layout.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] WA_RT    = 2'b00;
    localparam logic [1:0] WA_RD    = 2'b01;
    localparam logic [1:0] WA_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_DM    = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_REG  = 2'b11;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;

    // Bit positions in the one-hot class vector; all-zero means undefined.
    localparam int C_ADDU    = 0;
    localparam int C_SUBU    = 1;
    localparam int C_JR      = 2;
    localparam int C_ORI     = 3;
    localparam int C_LW      = 4;
    localparam int C_SW      = 5;
    localparam int C_BEQ     = 6;
    localparam int C_LUI     = 7;
    localparam int C_JAL     = 8;
    localparam int NUM_CLASS = 9;

    typedef logic [NUM_CLASS-1:0] iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps the opcode/funct fields of the
// current instruction to a one-hot class (all zeros for anything undefined).
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     iclass
);

    // Register, shamt and immediate fields play no part in classification.
    logic unused_fields;
    assign unused_fields = ^instr[25:6];

    always_comb begin
        iclass = '0;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADDU: iclass[C_ADDU] = 1'b1;
                    FN_SUBU: iclass[C_SUBU] = 1'b1;
                    FN_JR:   iclass[C_JR]   = 1'b1;
                    default: iclass = '0;
                endcase
            end
            OP_ORI:  iclass[C_ORI] = 1'b1;
            OP_LW:   iclass[C_LW]  = 1'b1;
            OP_SW:   iclass[C_SW]  = 1'b1;
            OP_BEQ:  iclass[C_BEQ] = 1'b1;
            OP_LUI:  iclass[C_LUI] = 1'b1;
            OP_JAL:  iclass[C_JAL] = 1'b1;
            default: iclass = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: five-state FSM driving the datapath
// enables/selects, plus a free-running retired-instruction counter.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        dm_ack,
    output logic        pc_we,
    output logic        ir_we,
    output logic        grf_we,
    output logic        dm_we,
    output logic        dm_req,
    output logic [1:0]  wa_sel,
    output logic        alu_src,
    output logic [1:0]  wd_sel,
    output logic [2:0]  alu_op,
    output logic        ext_op,
    output logic [1:0]  npc_sel,
    output logic [2:0]  state,
    output logic [31:0] retire_cnt
);

    state_t      state_q;
    state_t      state_d;
    iclass_t     iclass;
    logic [31:0] retire_cnt_q;
    logic        is_alu;
    logic        is_undef;

    mc_decode u_decode (
        .instr  (instr),
        .iclass (iclass)
    );

    assign is_alu   = iclass[C_ADDU] | iclass[C_SUBU] | iclass[C_ORI] | iclass[C_LUI];
    assign is_undef = (iclass == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_FETCH;
        pc_we   = 1'b0;
        ir_we   = 1'b0;
        grf_we  = 1'b0;
        dm_we   = 1'b0;
        dm_req  = 1'b0;
        wa_sel  = WA_RT;
        wd_sel  = WD_ALU;
        npc_sel = NPC_PC4;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        ext_op  = 1'b0;

        // ALU controls stay stable through EXEC, MEM and WB so the datapath
        // does not need to latch them.
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            if (iclass[C_SUBU] || iclass[C_BEQ]) begin
                alu_op = ALU_SUB;
            end else if (iclass[C_ORI]) begin
                alu_src = 1'b1;
                alu_op  = ALU_OR;
            end else if (iclass[C_LUI]) begin
                alu_src = 1'b1;
                alu_op  = ALU_LUI;
            end else if (iclass[C_LW] || iclass[C_SW]) begin
                alu_src = 1'b1;
                ext_op  = 1'b1;
            end
        end

        case (state_q)
            ST_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (iclass[C_JAL]) begin
                    state_d = ST_WB;
                end else if (iclass[C_JR]) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_REG;
                end else if (!is_undef) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (iclass[C_BEQ]) begin
                    pc_we   = zero;
                    npc_sel = NPC_BR;
                end else if (iclass[C_LW] || iclass[C_SW]) begin
                    state_d = ST_MEM;
                end else if (is_alu) begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dm_req  = 1'b1;
                dm_we   = iclass[C_SW];
                state_d = ST_MEM;
                if (dm_ack) begin
                    state_d = iclass[C_LW] ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                grf_we = 1'b1;
                if (iclass[C_ADDU] || iclass[C_SUBU]) begin
                    wa_sel = WA_RD;
                end else if (iclass[C_LW]) begin
                    wd_sel = WD_DM;
                end else if (iclass[C_JAL]) begin
                    wa_sel  = WA_RA;
                    wd_sel  = WD_PC4;
                    pc_we   = 1'b1;
                    npc_sel = NPC_JUMP;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Keep the PC and IR frozen while reset is held.
        if (!rst_n) begin
            ir_we = 1'b0;
            pc_we = 1'b0;
        end
    end

    // An instruction retires on the edge that brings the FSM back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= 32'd0;
        end else if (state_q != ST_FETCH && state_d == ST_FETCH) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign state      = state_q;
    assign retire_cnt = retire_cnt_q;

endmodule
